// File: rtl/riscv_hazard_ctrl_pkg.sv
// +-------------------------------------------------------------------------+
// | riscv_hazard_ctrl_pkg: shared encodings for the hazard controller. Rev 1.0 |
// +-------------------------------------------------------------------------+
`default_nettype none

package riscv_hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_EM = 2'b01;
  localparam logic [1:0] FWD_MW = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2
  } dmem_state_t;

endpackage

`default_nettype wire

// File: rtl/riscv_hazard_ctrl_fwd.sv
// +-------------------------------------------------------------------------+
// | riscv_fwd_unit: EX operand forwarding selects, EM over MW.      Rev 1.0 |
// +-------------------------------------------------------------------------+
`default_nettype none

module riscv_fwd_unit
  import riscv_hazard_ctrl_pkg::*;
(
  input  logic [4:0] e_rs1_addr,
  input  logic [4:0] e_rs2_addr,
  input  logic [4:0] m_rd_addr,
  input  logic       m_reg_wr_en,
  input  logic       m_is_load,
  input  logic [4:0] w_rd_addr,
  input  logic       w_reg_wr_en,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel
);

  // A load in EM has no data yet, so it can only be picked up once it reaches MW
  function automatic logic [1:0] pick(input logic [4:0] rs);
    if (m_reg_wr_en && !m_is_load && (m_rd_addr != 5'd0) && (m_rd_addr == rs))
      return FWD_EM;
    else if (w_reg_wr_en && (w_rd_addr != 5'd0) && (w_rd_addr == rs))
      return FWD_MW;
    else
      return FWD_RF;
  endfunction

  assign fwd_a_sel = pick(e_rs1_addr);
  assign fwd_b_sel = pick(e_rs2_addr);

endmodule

`default_nettype wire

// File: rtl/riscv_hazard_ctrl.sv
// +-------------------------------------------------------------------------+
// | riscv_hazard_ctrl: stage enables/flushes, dmem handshake, stalls. Rev 1.0 |
// +-------------------------------------------------------------------------+
`default_nettype none

module riscv_hazard_ctrl
  import riscv_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DMEM_TIMEOUT = 255,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [4:0]       i_d_rs1_addr,
  input  logic [4:0]       i_d_rs2_addr,
  input  logic [4:0]       i_e_rs1_addr,
  input  logic [4:0]       i_e_rs2_addr,
  input  logic [4:0]       i_e_rd_addr,
  input  logic             i_e_is_load,
  input  logic             i_e_branch_taken,
  input  logic [4:0]       i_m_rd_addr,
  input  logic             i_m_reg_wr_en,
  input  logic             i_m_is_load,
  input  logic             i_m_mem_wr_en,
  input  logic [4:0]       i_w_rd_addr,
  input  logic             i_w_reg_wr_en,
  input  logic             i_dmem_ack,
  output logic             o_dmem_req,
  output logic             o_pc_en,
  output logic             o_fd_en,
  output logic             o_de_en,
  output logic             o_em_en,
  output logic             o_mw_en,
  output logic             o_fd_flush,
  output logic             o_de_flush,
  output logic [1:0]       o_fwd_a_sel,
  output logic [1:0]       o_fwd_b_sel,
  output logic             o_dmem_err,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam logic [15:0] TIMEOUT_VAL = 16'(DMEM_TIMEOUT);

  dmem_state_t      state;
  dmem_state_t      state_nxt;
  logic [15:0]      wait_cnt;
  logic [15:0]      wait_cnt_nxt;
  logic             err_set;
  logic             req;
  logic             mem_op;
  logic             mem_stall;
  logic             load_use;
  logic [CNT_W-1:0] stall_cnt;

  assign mem_op   = i_m_is_load | i_m_mem_wr_en;
  assign load_use = i_e_is_load && (i_e_rd_addr != 5'd0) &&
                    ((i_e_rd_addr == i_d_rs1_addr) || (i_e_rd_addr == i_d_rs2_addr));

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state    <= IDLE;
      wait_cnt <= 16'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    err_set      = 1'b0;
    req          = 1'b0;
    mem_stall    = 1'b0;
    case (state)
      IDLE: begin
        req          = mem_op;
        wait_cnt_nxt = 16'd0;
        if (mem_op && !i_dmem_ack) begin
          mem_stall = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        req = 1'b1;
        if (i_dmem_ack) begin
          state_nxt    = IDLE;
          wait_cnt_nxt = 16'd0;
        end else begin
          mem_stall    = 1'b1;
          wait_cnt_nxt = wait_cnt + 16'd1;
          if (wait_cnt_nxt == TIMEOUT_VAL) begin
            state_nxt = HALT;
            err_set   = 1'b1;
          end
        end
      end
      HALT: begin
        mem_stall = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // A frozen pipe drops branch/load-use responses; they re-evaluate after release
  always_comb begin
    o_pc_en    = 1'b1;
    o_fd_en    = 1'b1;
    o_de_en    = 1'b1;
    o_em_en    = 1'b1;
    o_mw_en    = 1'b1;
    o_fd_flush = 1'b0;
    o_de_flush = 1'b0;
    if (mem_stall) begin
      o_pc_en = 1'b0;
      o_fd_en = 1'b0;
      o_de_en = 1'b0;
      o_em_en = 1'b0;
      o_mw_en = 1'b0;
    end else if (i_e_branch_taken) begin
      o_fd_flush = 1'b1;
      o_de_flush = 1'b1;
    end else if (load_use) begin
      o_pc_en    = 1'b0;
      o_fd_en    = 1'b0;
      o_de_flush = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_dmem_err <= 1'b0;
      stall_cnt  <= '0;
    end else begin
      if (err_set)
        o_dmem_err <= 1'b1;
      if (!o_pc_en && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign o_stall_cnt = stall_cnt;
  assign o_dmem_req  = req & i_rstn;

  riscv_fwd_unit u_fwd (
    .e_rs1_addr  (i_e_rs1_addr),
    .e_rs2_addr  (i_e_rs2_addr),
    .m_rd_addr   (i_m_rd_addr),
    .m_reg_wr_en (i_m_reg_wr_en),
    .m_is_load   (i_m_is_load),
    .w_rd_addr   (i_w_rd_addr),
    .w_reg_wr_en (i_w_reg_wr_en),
    .fwd_a_sel   (o_fwd_a_sel),
    .fwd_b_sel   (o_fwd_b_sel)
  );

endmodule

`default_nettype wire
